// File: rtl/lv_owt_tx_ctrl.sv
// LV-side one-wire frame transmitter.
// Sends a Manchester-coded frame on the LV->HV wire:
//   sync head, sync tail, cmd, data, CRC8, end tail, idle gap.
// The line output is registered. Its next level is derived from the next
// FSM position, so each level change lands exactly on a half-bit boundary.
module lv_owt_tx_ctrl #(
    parameter int OWT_HB_CYC       = 8,
    parameter int OWT_SYNC_BIT_NUM = 12,
    parameter int OWT_TAIL_BIT_NUM = 4,
    parameter int OWT_CMD_BIT_NUM  = 8,
    parameter int OWT_DATA_BIT_NUM = 8,
    parameter int OWT_CRC_BIT_NUM  = 8,
    parameter int OWT_GAP_HB_NUM   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_owt_tx_req,
    input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
    input  logic [OWT_DATA_BIT_NUM-1:0] i_owt_tx_data,
    output logic                        o_owt_tx_ready,
    output logic                        o_owt_tx_busy,
    output logic                        o_owt_tx_done,
    output logic [OWT_CMD_BIT_NUM-1:0]  o_owt_last_tx_cmd,
    output logic                        o_lv_hv_owt_tx
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_HB = max2(max2(2*OWT_SYNC_BIT_NUM, max2(OWT_TAIL_BIT_NUM, OWT_GAP_HB_NUM)),
                                 2*max2(OWT_CMD_BIT_NUM, max2(OWT_DATA_BIT_NUM, OWT_CRC_BIT_NUM)));
    localparam int IDX_W  = max2($clog2(MAX_HB), 1);
    localparam int CNT_W  = max2($clog2(OWT_HB_CYC), 1);
    localparam int SR_W   = max2(OWT_CMD_BIT_NUM, max2(OWT_DATA_BIT_NUM, OWT_CRC_BIT_NUM));

    localparam logic [IDX_W-1:0] LAST_SYNC = IDX_W'(2*OWT_SYNC_BIT_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_TAIL = IDX_W'(OWT_TAIL_BIT_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_CMD  = IDX_W'(2*OWT_CMD_BIT_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(2*OWT_DATA_BIT_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_CRC  = IDX_W'(2*OWT_CRC_BIT_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_GAP  = IDX_W'(OWT_GAP_HB_NUM - 1);
    localparam logic [IDX_W-1:0] TAIL_HI   = IDX_W'(OWT_TAIL_BIT_NUM / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(OWT_HB_CYC - 1);
    localparam logic [OWT_CRC_BIT_NUM-1:0] CRC_POLY = OWT_CRC_BIT_NUM'(8'h07);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC_HEAD, ST_SYNC_TAIL, ST_CMD,
        ST_DATA, ST_CRC, ST_END_TAIL, ST_GAP
    } state_t;

    state_t                      state, nxt_state;
    logic [CNT_W-1:0]            hb_cnt, nxt_cnt;
    logic [IDX_W-1:0]            hb_idx, nxt_idx, idx_last;
    logic [SR_W-1:0]             sr, nxt_sr;
    logic [OWT_CMD_BIT_NUM-1:0]  cmd_q, last_cmd_q;
    logic [OWT_DATA_BIT_NUM-1:0] data_q;
    logic [OWT_CRC_BIT_NUM-1:0]  crc_q, crc_nxt;
    logic                        line_q, line_d, done_q, done_d;
    logic                        accept, hb_end, crc_upd, crc_fb;

    assign accept  = (state == ST_IDLE) && i_owt_tx_req;
    assign hb_end  = (hb_cnt == LAST_CNT);
    // CRC steps once per cmd/data bit, on the first cycle of its first half
    assign crc_upd = ((state == ST_CMD) || (state == ST_DATA)) && (hb_cnt == '0) && !hb_idx[0];
    assign crc_fb  = crc_q[OWT_CRC_BIT_NUM-1] ^ sr[SR_W-1];
    assign crc_nxt = {crc_q[OWT_CRC_BIT_NUM-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);

    assign o_owt_tx_ready    = (state == ST_IDLE);
    assign o_owt_tx_busy     = (state != ST_IDLE);
    assign o_owt_tx_done     = done_q;
    assign o_owt_last_tx_cmd = last_cmd_q;
    assign o_lv_hv_owt_tx    = line_q;

    // Index of the final half-bit of the current state
    always_comb begin
        idx_last = '0;
        case (state)
            ST_SYNC_HEAD:            idx_last = LAST_SYNC;
            ST_SYNC_TAIL, ST_END_TAIL: idx_last = LAST_TAIL;
            ST_CMD:                  idx_last = LAST_CMD;
            ST_DATA:                 idx_last = LAST_DATA;
            ST_CRC:                  idx_last = LAST_CRC;
            ST_GAP:                  idx_last = LAST_GAP;
            default:                 idx_last = '0;
        endcase
    end

    // Next FSM position, field shift register and end-of-frame pulse
    always_comb begin
        nxt_state = state;
        nxt_cnt   = hb_cnt;
        nxt_idx   = hb_idx;
        nxt_sr    = sr;
        done_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_owt_tx_req) begin
                    nxt_state = ST_SYNC_HEAD;
                    nxt_cnt   = '0;
                    nxt_idx   = '0;
                end
            end
            ST_SYNC_HEAD, ST_SYNC_TAIL, ST_CMD, ST_DATA, ST_CRC, ST_END_TAIL, ST_GAP: begin
                if (!hb_end) begin
                    nxt_cnt = hb_cnt + 1'b1;
                end else begin
                    nxt_cnt = '0;
                    if (hb_idx == idx_last) begin
                        nxt_idx = '0;
                        case (state)
                            ST_SYNC_HEAD: nxt_state = ST_SYNC_TAIL;
                            ST_SYNC_TAIL: begin
                                nxt_state = ST_CMD;
                                nxt_sr    = SR_W'(cmd_q) << (SR_W - OWT_CMD_BIT_NUM);
                            end
                            ST_CMD: begin
                                nxt_state = ST_DATA;
                                nxt_sr    = SR_W'(data_q) << (SR_W - OWT_DATA_BIT_NUM);
                            end
                            ST_DATA: begin
                                nxt_state = ST_CRC;
                                nxt_sr    = SR_W'(crc_q) << (SR_W - OWT_CRC_BIT_NUM);
                            end
                            ST_CRC:      nxt_state = ST_END_TAIL;
                            ST_END_TAIL: nxt_state = ST_GAP;
                            default: begin
                                nxt_state = ST_IDLE;
                                done_d    = (state == ST_GAP);
                            end
                        endcase
                    end else begin
                        nxt_idx = hb_idx + 1'b1;
                        // advance to the next field bit after its second half
                        if (hb_idx[0]) nxt_sr = sr << 1;
                    end
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
                nxt_idx   = '0;
            end
        endcase
    end

    // Line level for the upcoming cycle (Manchester 0 = high,low; 1 = low,high)
    always_comb begin
        line_d = 1'b1;
        case (nxt_state)
            ST_SYNC_HEAD:              line_d = ~nxt_idx[0];
            ST_SYNC_TAIL, ST_END_TAIL: line_d = (nxt_idx < TAIL_HI);
            ST_CMD, ST_DATA, ST_CRC:   line_d = nxt_idx[0] ? nxt_sr[SR_W-1] : ~nxt_sr[SR_W-1];
            default:                   line_d = 1'b1;
        endcase
    end

    // FSM, counters and line register; reset drops the line back to idle-high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            hb_cnt <= '0;
            hb_idx <= '0;
            sr     <= '0;
            line_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            hb_cnt <= nxt_cnt;
            hb_idx <= nxt_idx;
            sr     <= nxt_sr;
            line_q <= line_d;
            done_q <= done_d;
        end
    end

    // Request latch and serial CRC over cmd then data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q      <= '0;
            data_q     <= '0;
            last_cmd_q <= '0;
            crc_q      <= '0;
        end else if (accept) begin
            cmd_q      <= i_owt_tx_cmd;
            data_q     <= i_owt_tx_data;
            last_cmd_q <= i_owt_tx_cmd;
            crc_q      <= '0;
        end else if (crc_upd) begin
            crc_q      <= crc_nxt;
        end
    end

endmodule
